// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: memory handshake, watchdog, illegal-opcode trap.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_controller #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             addr_src,
   output logic             instr_flop_wen,
   output logic             pc_wen,
   output logic             reg_write,
   output logic [1:0]       alu_a_src,
   output logic [1:0]       alu_b_src,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic [2:0]       imm_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_B     = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_EXEC_R, S_EXEC_I, S_EXEC_U, S_EXEC_B, S_EXEC_J, S_EXEC_JALR,
      S_LINK, S_ALU_WB, S_TRAP
   } state_t;

   state_t              state_q, state_d, dispatch_c;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                trap_q, trap_d;
   logic [1:0]          cause_q, cause_d;
   logic                illegal_c, taken_c, timeout_c;
   logic                req_c, wr_c, asrc_c, ifw_c, pcw_c, rw_c;
   logic [1:0]          a_c, b_c, op_c, rs_c;
   logic [2:0]          imm_c;

   assign timeout_c = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

   // Opcode dispatch and legality check; the full 7-bit opcode must match.
   always_comb begin
      illegal_c  = 1'b0;
      dispatch_c = S_TRAP;
      imm_c      = 3'd0;
      case (opcode)
         OPC_R: begin
            dispatch_c = S_EXEC_R;
            illegal_c  = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
         end
         OPC_I:               dispatch_c = S_EXEC_I;
         OPC_LUI, OPC_AUIPC: begin dispatch_c = S_EXEC_U; imm_c = 3'd4; end
         OPC_B: begin
            dispatch_c = S_EXEC_B;
            imm_c      = 3'd2;
            illegal_c  = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_JAL: begin dispatch_c = S_EXEC_J; imm_c = 3'd3; end
         OPC_JALR: begin
            dispatch_c = S_EXEC_JALR;
            illegal_c  = (funct3 != 3'b000);
         end
         OPC_LOAD: begin
            dispatch_c = S_MEM_ADDR;
            illegal_c  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            dispatch_c = S_MEM_ADDR;
            imm_c      = 3'd1;
            illegal_c  = (funct3 > 3'b010);
         end
         default: illegal_c = 1'b1;
      endcase
      if (illegal_c) dispatch_c = S_TRAP;
   end

   always_comb begin
      case (funct3)
         3'b000:  taken_c = alu_zero;
         3'b001:  taken_c = !alu_zero;
         3'b100:  taken_c = alu_lt;
         3'b101:  taken_c = !alu_lt;
         3'b110:  taken_c = alu_ltu;
         3'b111:  taken_c = !alu_ltu;
         default: taken_c = 1'b0;
      endcase
   end

   // Next-state and control decode.
   always_comb begin
      state_d = state_q;
      trap_d  = trap_q;
      cause_d = cause_q;
      req_c = 1'b0; wr_c = 1'b0; asrc_c = 1'b0;
      ifw_c = 1'b0; pcw_c = 1'b0; rw_c = 1'b0;
      a_c = 2'd0; b_c = 2'd0; op_c = 2'd0; rs_c = 2'd0;
      case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               ifw_c = 1'b1; pcw_c = 1'b1; b_c = 2'd2; rs_c = 2'd2;
               state_d = S_DECODE;
            end else if (timeout_c) begin
               state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd2;
            end
         end
         S_DECODE: begin
            a_c = 2'd1; b_c = 2'd1;
            state_d = dispatch_c;
            if (illegal_c) begin trap_d = 1'b1; cause_d = 2'd1; end
         end
         S_MEM_ADDR: begin
            a_c = 2'd2; b_c = 2'd1;
            state_d = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ, S_MEM_WRITE: begin
            req_c  = 1'b1;
            asrc_c = 1'b1;
            wr_c   = (state_q == S_MEM_WRITE);
            if (mem_ready) begin
               state_d = (state_q == S_MEM_WRITE) ? S_FETCH : S_MEM_WB;
            end else if (timeout_c) begin
               state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd2;
            end
         end
         S_MEM_WB: begin rs_c = 2'd1; rw_c = 1'b1; state_d = S_FETCH; end
         S_EXEC_R: begin a_c = 2'd2; op_c = 2'd2; state_d = S_ALU_WB; end
         S_EXEC_I: begin a_c = 2'd2; b_c = 2'd1; op_c = 2'd2; state_d = S_ALU_WB; end
         S_EXEC_U: begin
            a_c = (opcode == OPC_LUI) ? 2'd3 : 2'd1;
            b_c = 2'd1;
            state_d = S_ALU_WB;
         end
         S_EXEC_B: begin
            a_c = 2'd2; op_c = 2'd1; pcw_c = taken_c;
            state_d = S_FETCH;
         end
         S_EXEC_J: begin pcw_c = 1'b1; a_c = 2'd1; b_c = 2'd2; state_d = S_ALU_WB; end
         S_EXEC_JALR: begin
            a_c = 2'd2; b_c = 2'd1; rs_c = 2'd2; pcw_c = 1'b1;
            state_d = S_LINK;
         end
         S_LINK:   begin a_c = 2'd1; b_c = 2'd2; state_d = S_ALU_WB; end
         S_ALU_WB: begin rw_c = 1'b1; state_d = S_FETCH; end
         default:  state_d = S_TRAP;
      endcase
   end

   // Wait counter restarts on every state change, so it is zero on entry to each access.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q)                             wait_d = '0;
      else if ((TIMEOUT != 0) && req_c && !mem_ready)     wait_d = wait_q + WAIT_W'(1);
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] instret_q, stall_q;
   logic             retire_c;

   assign retire_c = (state_d == S_FETCH) &&
                     ((state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                      (state_q == S_MEM_WRITE) || (state_q == S_EXEC_B));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         trap_q  <= 1'b0;
         cause_q <= 2'd0;
`ifdef CTRL_PERF_CNT_EN
         instret_q <= '0;
         stall_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
`ifdef CTRL_PERF_CNT_EN
         if (retire_c)              instret_q <= instret_q + CNT_W'(1);
         if (req_c && !mem_ready)   stall_q   <= stall_q + CNT_W'(1);
`endif
      end
   end

   // Reset forces every output low, including any access in flight.
   assign mem_req        = !rst && req_c;
   assign mem_write      = !rst && wr_c;
   assign addr_src       = !rst && asrc_c;
   assign instr_flop_wen = !rst && ifw_c;
   assign pc_wen         = !rst && pcw_c;
   assign reg_write      = !rst && rw_c;
   assign alu_a_src      = rst ? 2'd0 : a_c;
   assign alu_b_src      = rst ? 2'd0 : b_c;
   assign alu_op         = rst ? 2'd0 : op_c;
   assign result_src     = rst ? 2'd0 : rs_c;
   assign imm_sel        = rst ? 3'd0 : imm_c;
   assign trap           = !rst && trap_q;
   assign trap_cause     = rst ? 2'd0 : cause_q;
`ifdef CTRL_PERF_CNT_EN
   assign instret_cnt    = rst ? '0 : instret_q;
   assign stall_cnt      = rst ? '0 : stall_q;
`else
   assign instret_cnt    = '0;
   assign stall_cnt      = '0;
`endif
endmodule
